// File: rtl/prog_sequencer_pkg.sv
// Shared state encoding and constants for the program sequencer.
// The LUT power-up contents are the default branch targets that are restored on reset.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int IW_DEFAULT = 9;
  localparam logic [IW_DEFAULT-1:0] HALT_CODE = '1;

  // Reset image of the branch-target LUT: entry i points at address 8*i.
  localparam int LUT_INIT_N = 32;
  localparam logic [15:0] LUT_INIT [LUT_INIT_N] = '{
    16'h00, 16'h08, 16'h10, 16'h18, 16'h20, 16'h28, 16'h30, 16'h38,
    16'h40, 16'h48, 16'h50, 16'h58, 16'h60, 16'h68, 16'h70, 16'h78,
    16'h80, 16'h88, 16'h90, 16'h98, 16'hA0, 16'hA8, 16'hB0, 16'hB8,
    16'hC0, 16'hC8, 16'hD0, 16'hD8, 16'hE0, 16'hE8, 16'hF0, 16'hF8
  };

  // Deeper LUTs repeat the image so every entry has a defined reset value.
  function automatic logic [15:0] lut_init_val(int i);
    return LUT_INIT[i % LUT_INIT_N];
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Handshake, decoder and LUT-write bundle between the core and the program sequencer.
interface prog_sequencer_if #(
  parameter int PCW = 8,
  parameter int IW  = 9,
  parameter int LW  = 5,
  parameter int CW  = 16
);
  logic           req;
  logic           stall;
  logic [IW-1:0]  instr;
  logic           branch;
  logic           call;
  logic           ret;
  logic [LW-1:0]  lut_idx;
  logic           lut_we;
  logic [LW-1:0]  lut_wa;
  logic [PCW-1:0] lut_wd;
  logic [PCW-1:0] prog_ctr;
  logic           running;
  logic           done;
  logic           err;
  logic [CW-1:0]  cycles;

  // The core side drives requests and decode; the sequencer drives the PC and status.
  modport master (
    output req, stall, instr, branch, call, ret, lut_idx, lut_we, lut_wa, lut_wd,
    input  prog_ctr, running, done, err, cycles
  );

  modport slave (
    input  req, stall, instr, branch, call, ret, lut_idx, lut_we, lut_wa, lut_wd,
    output prog_ctr, running, done, err, cycles
  );
endinterface

// File: rtl/prog_sequencer_call_stack.sv
// Return-address LIFO for the sequencer: pointer-based, emptied by reset or program start.
module call_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH + 1);

  // Storage is sized to the pointer range so indexing needs no truncation.
  logic [W-1:0]  mem [2**PW];
  logic [PW-1:0] ptr_q;

  assign full  = (ptr_q == PW'(DEPTH));
  assign empty = (ptr_q == '0);
  assign top   = empty ? '0 : mem[ptr_q - 1'b1];

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr_q <= '0;
    end else if (push && !full) begin
      ptr_q <= ptr_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - 1'b1;
    end
  end

  // NOTE: only the pointer is reset; slots above it are never read, so the entries stay plain storage.
  always_ff @(posedge clk) begin
    if (!reset && !clear && push && !full) begin
      mem[ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: PC, writable branch-target LUT, call stack and registered req/done handshake.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int PCW        = 8,
  parameter int IW         = 9,
  parameter int LUT_DEPTH  = 32,
  parameter int STK_DEPTH  = 4,
  parameter int REL        = 0,
  parameter int START_ADDR = 0,
  parameter int CW         = 16
) (
  input logic             clk,
  input logic             reset,
  prog_sequencer_if.slave bus
);
  localparam int LW = $clog2(LUT_DEPTH);
  localparam logic [PCW-1:0] START_PC = PCW'(START_ADDR);

  seq_state_e     state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [CW-1:0]  cycles_q;
  logic           err_q;

  logic [PCW-1:0] lut [LUT_DEPTH];
  logic [LW-1:0]  rd_idx;
  logic [PCW-1:0] lut_rd;
  logic [PCW-1:0] target;
  logic [IW-1:0]  instr;
  logic           is_halt;

  logic           start;
  logic           err_set;
  logic           stk_push;
  logic           stk_pop;
  logic           stk_full;
  logic           stk_empty;
  logic [PCW-1:0] stk_top;

  assign instr   = bus.instr;
  assign is_halt = &instr;
  assign rd_idx  = bus.lut_idx;
  assign lut_rd  = lut[rd_idx];
  // Relative targets wrap modulo the program space, which the PCW-wide add gives for free.
  assign target  = (REL != 0) ? pc_q + lut_rd : lut_rd;

  // The LUT is read combinationally, so a same-cycle write still returns the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut[i] <= PCW'(lut_init_val(i));
      end
    end else if (bus.lut_we) begin
      lut[bus.lut_wa] <= bus.lut_wd;
    end
  end

  call_stack #(
    .DEPTH (STK_DEPTH),
    .W     (PCW)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .clear     (start),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_q + 1'b1),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    start    = 1'b0;
    err_set  = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        pc_d = START_PC;
        if (bus.req) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          if (is_halt) begin
            state_d = DONE;
          end else if (bus.ret) begin
            if (stk_empty) begin
              err_set = 1'b1;
              state_d = DONE;
            end else begin
              stk_pop = 1'b1;
              pc_d    = stk_top;
            end
          end else if (bus.call) begin
            if (stk_full) begin
              err_set = 1'b1;
              state_d = DONE;
            end else begin
              stk_push = 1'b1;
              pc_d     = target;
            end
          end else if (bus.branch) begin
            pc_d = target;
          end else if (pc_q == '1) begin
            // Running off the end of program space completes the program instead of wrapping.
            state_d = DONE;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (!bus.req) begin
          state_d = IDLE;
          pc_d    = START_PC;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= START_PC;
      err_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (start) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
      if (start) begin
        cycles_q <= '0;
      end else if (state_q == RUN && cycles_q != '1) begin
        cycles_q <= cycles_q + 1'b1;
      end
    end
  end

  assign bus.prog_ctr = pc_q;
  assign bus.running  = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.err      = err_q;
  assign bus.cycles   = cycles_q;

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Parametrised program sequencer for the 9-bit teaching core. It owns the program counter, a writable branch-target LUT, a call/return stack, and a registered req/done handshake. The instruction ROM and control decoder sit around it: the ROM is addressed by `prog_ctr`, and the decoder supplies `branch`/`call`/`ret`/`lut_idx`. It replaces the core's plain PC, fixed PC LUT and combinational done logic.

## Interface
Parameters:
- `PCW`, 8: program counter width; program space is 2^PCW words.
- `IW`, 9: instruction width.
- `LUT_DEPTH`, 32: branch-target LUT entries; index width `LW = $clog2(LUT_DEPTH)`.
- `STK_DEPTH`, 4: call-stack entries, minimum 1.
- `REL`, 0: branch target mode; 0 = absolute LUT value, 1 = `prog_ctr` + sign-extended LUT value.
- `START_ADDR`, 0: PC value at program start.
- `CW`, 16: cycle-counter width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req`  in  1  start request; level, held until `done` is seen.
- `stall`  in  1  freeze PC and stack this cycle.
- `instr`  in  IW  machine code at current `prog_ctr`.
- `branch`  in  1  take LUT jump (flag-qualified by the decoder).
- `call`  in  1  push return address, then take LUT jump.
- `ret`  in  1  pop return address into PC.
- `lut_idx`  in  LW  LUT read index for `branch`/`call`.
- `lut_we`  in  1  LUT write enable.
- `lut_wa`  in  LW  LUT write index.
- `lut_wd`  in  PCW  LUT write data.
- `prog_ctr`  out  PCW  current instruction address.
- `running`  out  1  high in RUN.
- `done`  out  1  program complete (registered).
- `err`  out  1  sticky stack overflow/underflow.
- `cycles`  out  CW  RUN cycles since start, saturating.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `prog_ctr` = START_ADDR.
  - `req`=1 → RUN. On that edge: `cycles`←0, `err`←0, stack emptied.
- RUN, per cycle with `stall`=0, first match wins:
  1. `instr` == all ones (HALT) → DONE; PC holds.
  2. `ret`: stack empty → `err`←1, DONE; else PC ← pop.
  3. `call`: stack full → `err`←1, DONE; else push `prog_ctr`+1, PC ← target.
  4. `branch`: PC ← target.
  5. Otherwise: PC ← `prog_ctr`+1. If `prog_ctr` == 2^PCW−1, go to DONE instead; no wrap.
- Target arithmetic:
  - REL=0: `lut[lut_idx]`.
  - REL=1: (`prog_ctr` + `lut[lut_idx]`) mod 2^PCW; wraps silently.
- `stall`=1 in RUN: PC, stack and FSM hold; HALT is not evaluated; `cycles` still increments.
- `call`+`ret` together: `ret` wins and `call` is ignored (decoder error case).
- `cycles` increments every RUN cycle and saturates at all ones.
- DONE: `done`=1, PC holds. `req`=0 → IDLE. `req` must drop before a new start, so a held `req` never restarts.
- LUT:
  - `lut_we` is accepted in any state; the write is visible from the next cycle.
  - Same-cycle read of the written index returns the old value.
- `reset` in any state, including mid-program:
  - state→IDLE, `prog_ctr`=START_ADDR, `done`=0, `running`=0, `err`=0, `cycles`=0, stack empty.
  - LUT entries ← `LUT_INIT[i]`.

## Timing
- All outputs are registered; no combinational input→output path.
- `instr` is combinational from the ROM at the current `prog_ctr`. The decision is taken in that cycle and the new PC appears after the next edge.
- Start latency: `req` sampled high in IDLE → `running`=1 the next cycle, with `prog_ctr`=START_ADDR.
- Halt latency: HALT present at edge N → `done`=1 and `running`=0 after edge N. `cycles` includes the HALT cycle.
- Handshake release: `req` low in DONE → `done`=0 after the next edge.

## Structure
- Package `seq_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - `HALT_CODE` (all ones, IW bits).
  - `LUT_INIT` constant array.
- Sub-module `call_stack`: LIFO of STK_DEPTH×PCW with `push`, `pop`, `full`, `empty`; pointer-based, synchronous, cleared by reset or start.
- LUT and FSM live in `prog_sequencer`.

## Test plan
- Straight line: reset, `req`=1, ROM HALT at address 5 → `prog_ctr` 0..5, `done`=1 one cycle after PC=5, `cycles`=6; `req`=0 → IDLE, `done`=0.
- Branch, REL=0: write `lut[3]`=20, `branch`=1 with `lut_idx`=3 at PC=2 → next PC=20. REL=1, `lut[3]`=8'hFE at PC=10 → next PC=8.
- Call/ret, STK_DEPTH=2: call at 4 → PC=target, ret → PC=5. Third nested call → `err`=1, DONE.
- Underflow and end of space: ret with empty stack → `err`=1, `done`=1. No HALT: PC 255 → DONE, no wrap to 0.
- Stall and reset: `stall` for 3 cycles at PC=7 → PC holds 7, `cycles` +3. Reset at PC=9 → IDLE, PC=0, all outputs 0, LUT = `LUT_INIT`.
- LUT write/read same index and cycle → old target used; following cycle → new target used.
